bus_generator_arbiter: RTL and testbench



---
 rtl/bus_generator_arbiter.sv | 124 ++++++++++++
 tb/tb_bus_generator_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_generator_arbiter.sv
// bus_generator_arbiter
// Single bus master linking `drvrs` device FIFOs over a broadcast data bus.
// A round-robin arbiter grants one pending device, pops its head packet,
// then pushes the packet into the destination FIFO(s) named in bits
// [pckg_sz-1 -: 8] of the packet.
// Optional feature macro: BS_BROADCAST_EN. When it is defined, ID == broadcast
// goes to every device except the source. When it is undefined, that ID is
// treated as invalid and the packet is dropped.
module bus_generator_arbiter #(
  parameter int          pckg_sz   = 16,
  parameter int          drvrs     = 4,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [drvrs-1:0]                pndng,
  input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
  output logic [drvrs-1:0]                pop,
  output logic [drvrs-1:0]                push,
  output logic [drvrs-1:0][pckg_sz-1:0]   D_push
);

  localparam int IW = (drvrs > 1) ? $clog2(drvrs) : 1;

`ifdef BS_BROADCAST_EN
  localparam bit bcast_en = 1'b1;
`else
  localparam bit bcast_en = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, POP, PUSH} state_t;

  state_t             state, state_nxt;
  // `last` is also the current grant `g`: both are written only on a grant.
  logic [IW-1:0]      last;
  logic [IW-1:0]      grant, cand;
  logic               grant_vld;
  logic [pckg_sz-1:0] pkt;
  logic [pckg_sz-1:0] head;
  logic [7:0]         dest_id;
  logic [drvrs-1:0]   dest_mask;
  logic [drvrs-1:0]   pop_nxt, push_nxt;

  // Round-robin search: first pending device scanning upward from last+1.
  always_comb begin
    // NOTE: every variable gets a default before any branch writes it, so no
    // path leaves it unassigned and no latch is inferred.
    grant_vld = 1'b0;
    grant     = last;
    cand      = last;
    for (int i = 1; i <= drvrs; i++) begin
      cand = IW'((int'(last) + i) % drvrs);
      if (!grant_vld && pndng[cand]) begin
        grant_vld = 1'b1;
        grant     = cand;
      end
    end
  end

  // Destination decode of the granted device's head word.
  assign head    = D_pop[last];
  assign dest_id = head[pckg_sz-1 -: 8];

  // Destination mask: one-hot unicast, broadcast minus the source, or empty.
  always_comb begin
    dest_mask = '0;
    if (int'(dest_id) < drvrs) begin
      for (int i = 0; i < drvrs; i++) begin
        dest_mask[i] = (int'(dest_id) == i);
      end
    end else if (bcast_en && (dest_id == broadcast)) begin
      dest_mask       = '1;
      dest_mask[last] = 1'b0;
    end
  end

  // Next-state and next-output logic; pop/push are registered below.
  always_comb begin
    state_nxt = state;
    pop_nxt   = '0;
    push_nxt  = '0;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          state_nxt      = POP;
          pop_nxt[grant] = 1'b1;
        end
      end
      POP: begin
        state_nxt = PUSH;
        push_nxt  = dest_mask;
      end
      PUSH:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, grant memory, packet capture and registered Moore outputs.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block evaluation order.
    if (reset) begin
      state <= IDLE;
      last  <= IW'(drvrs - 1);
      pkt   <= '0;
      pop   <= '0;
      push  <= '0;
    end else begin
      state <= state_nxt;
      pop   <= pop_nxt;
      push  <= push_nxt;
      if (state == IDLE && grant_vld) begin
        last <= grant;
      end
      if (state == POP) begin
        pkt <= head;
      end
    end
  end

  // Every bus lane carries the same captured packet.
  assign D_push = {drvrs{pkt}};

endmodule

// File: tb/tb_bus_generator_arbiter.sv
// tb_bus_generator_arbiter
// Scoreboard bench: a transaction-level model predicts each pop and push
// (cycle, mask, data) from the arbitration rules; a monitor compares the
// DUT outputs against those predictions. Honors BS_BROADCAST_EN.
module tb_bus_generator_arbiter;

  localparam int         DRVRS = 4;
  localparam int         PW    = 16;
  localparam logic [7:0] BCAST = 8'hFF;

  typedef struct {
    int               cyc;
    logic [DRVRS-1:0] mask;
    logic [PW-1:0]    data;
  } exp_t;

  logic                       clk;
  logic                       reset;
  logic [DRVRS-1:0]           pndng;
  logic [DRVRS-1:0][PW-1:0]   D_pop;
  logic [DRVRS-1:0]           pop;
  logic [DRVRS-1:0]           push;
  logic [DRVRS-1:0][PW-1:0]   D_push;

  bus_generator_arbiter #(.pckg_sz(PW), .drvrs(DRVRS), .broadcast(BCAST)) dut (
    .clk    (clk),
    .reset  (reset),
    .pndng  (pndng),
    .D_pop  (D_pop),
    .pop    (pop),
    .push   (push),
    .D_push (D_push)
  );

  // Clock: period 10, rising edges at 5, 15, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [PW-1:0] dev_q [DRVRS][$];
  exp_t          exp_pop_q[$];
  exp_t          exp_push_q[$];

  // Model state
  int                       m_last = DRVRS - 1;
  int                       m_busy = 0;
  logic [DRVRS-1:0]         drv_pndng = '0;
  logic [DRVRS-1:0][PW-1:0] drv_data  = '0;
  logic [DRVRS-1:0]         prev_pop  = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Where a packet is delivered, derived from its header ID.
  function automatic logic [DRVRS-1:0] dest_of(input logic [PW-1:0] p, input int src);
    int id;
    id = int'(p[PW-1 -: 8]);
    if (id < DRVRS) return DRVRS'(1 << id);
`ifdef BS_BROADCAST_EN
    if (id == int'(BCAST)) return ~DRVRS'(1 << src);
`endif
    return '0;
  endfunction

  // Round robin: first requester after the previous winner, wrapping around.
  function automatic int next_grant(input logic [DRVRS-1:0] req, input int prev);
    for (int k = 1; k <= DRVRS; k++) begin
      if (req[(prev + k) % DRVRS]) return (prev + k) % DRVRS;
    end
    return -1;
  endfunction

  function automatic logic [PW-1:0] rand_pkt();
    logic [7:0] id;
    case ($urandom_range(0, 7))
      0: id = 8'h00;
      1: id = 8'h01;
      2: id = 8'h02;
      3: id = 8'h03;
      4: id = BCAST;
      5: id = 8'h04;
      6: id = 8'hA0;
      default: id = 8'($urandom_range(0, DRVRS - 1));
    endcase
    return {id, 8'($urandom)};
  endfunction

  // Device FIFOs and reference model, stepped on each falling edge.
  initial begin
    pndng = '0;
    D_pop = '0;
    forever begin
      @(negedge clk);
      cyc++;
      // Model: the rising edge just passed saw drv_pndng/drv_data.
      if (reset) begin
        m_last = DRVRS - 1;
        m_busy = 0;
        exp_pop_q.delete();
        exp_push_q.delete();
      end else if (m_busy > 0) begin
        m_busy--;
      end else if (drv_pndng != '0) begin
        int g;
        logic [DRVRS-1:0] m;
        exp_t e;
        g = next_grant(drv_pndng, m_last);
        m_last = g;
        e.cyc = cyc; e.mask = DRVRS'(1 << g); e.data = '0;
        exp_pop_q.push_back(e);
        m = dest_of(drv_data[g], g);
        if (m != '0) begin
          e.cyc = cyc + 1; e.mask = m; e.data = drv_data[g];
          exp_push_q.push_back(e);
        end
        m_busy = 2;
      end
      // Devices: a pop strobe seen last cycle completed at the edge just passed.
      for (int i = 0; i < DRVRS; i++) begin
        if (prev_pop[i] && dev_q[i].size() != 0) void'(dev_q[i].pop_front());
      end
      prev_pop = pop;
      for (int i = 0; i < DRVRS; i++) begin
        pndng[i] = (dev_q[i].size() != 0);
        D_pop[i] = (dev_q[i].size() != 0) ? dev_q[i][0] : '0;
      end
      drv_pndng = pndng;
      drv_data  = D_pop;
    end
  end

  // Monitor: compares DUT strobes against predicted transactions.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (exp_pop_q.size() != 0 && exp_pop_q[0].cyc < cyc) begin
        e = exp_pop_q.pop_front();
        check("pop_missing", 64'(cyc), 64'(e.cyc));
      end
      if (exp_push_q.size() != 0 && exp_push_q[0].cyc < cyc) begin
        e = exp_push_q.pop_front();
        check("push_missing", 64'(cyc), 64'(e.cyc));
      end
      if (pop != '0) begin
        check("pop_push_overlap", push, '0);
        if (exp_pop_q.size() == 0) begin
          check("pop_unexpected", pop, '0);
        end else begin
          e = exp_pop_q.pop_front();
          check("pop_mask", pop, e.mask);
          check("pop_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if (push != '0) begin
        if (exp_push_q.size() == 0) begin
          check("push_unexpected", push, '0);
        end else begin
          e = exp_push_q.pop_front();
          check("push_mask", push, e.mask);
          check("push_cycle", 64'(cyc), 64'(e.cyc));
          check("push_data", D_push, {DRVRS{e.data}});
        end
      end
    end
  end

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      #2;
      done = (exp_pop_q.size() == 0) && (exp_push_q.size() == 0) && (m_busy == 0) &&
             (dev_q[0].size() == 0) && (dev_q[1].size() == 0) &&
             (dev_q[2].size() == 0) && (dev_q[3].size() == 0);
    end
    check({name, "_drain_done"}, 64'(done), 64'd1);
  endtask

  // Directed and random scenarios.
  initial begin
    bit got;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    check("reset_pop", pop, '0);
    check("reset_push", push, '0);
    check("reset_dpush", D_push, '0);
    reset = 1'b0;

    dev_q[1].push_back(16'h02AB);  drain("unicast");
    dev_q[3].push_back(16'h0377);  drain("self_addr");
    dev_q[2].push_back(16'hFF55);  drain("broadcast");
    dev_q[0].push_back(16'h0A11);  drain("invalid_id");

    // Continuous demand from all devices.
    for (int n = 0; n < 3; n++) begin
      for (int d = 0; d < DRVRS; d++) dev_q[d].push_back({8'((d + 1 + n) % DRVRS), 8'(16 * d + n)});
    end
    drain("round_robin");

    // Reset during the PUSH cycle.
    dev_q[1].push_back(16'h0255);
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      #2;
      got = (push != '0);
    end
    check("rst_reach_push", 64'(got), 64'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_pop", pop, '0);
    check("rst_mid_push", push, '0);
    check("rst_mid_dpush", D_push, '0);
    dev_q[0].push_back(16'h0312);
    dev_q[3].push_back(16'h0134);
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b0;
    got = 1'b0;
    for (int t = 0; t < 10 && !got; t++) begin
      @(negedge clk);
      #2;
      if (pop != '0) begin
        got = 1'b1;
        check("rst_first_grant", pop, 4'b0001);
      end
    end
    check("rst_grant_seen", 64'(got), 64'd1);
    drain("after_reset");

    // Random traffic.
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      #2;
      if ($urandom_range(0, 2) == 0) begin
        int d;
        d = $urandom_range(0, DRVRS - 1);
        if (dev_q[d].size() < 4) dev_q[d].push_back(rand_pkt());
      end
    end
    drain("random");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Watchdog against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
